// File: rtl/btn_ram_writer_pkg.sv
// Shared types and constants for the manual RAM loader.
package btn_ram_writer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int unsigned BTN_WR = 0;
    localparam int unsigned BTN_NX = 1;
    localparam int unsigned BTN_RW = 2;

endpackage

// File: rtl/btn_ram_writer_if.sv
// Data-RAM write-port bundle driven by the manual loader; wren doubles as the port-mux select.
interface btn_ram_writer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              wren;
    logic [ADDR_W-1:0] mwAdress;
    logic [7:0]        mwData;
    logic              busy;

    modport master (output wren, output mwAdress, output mwData, output busy);
    modport slave  (input  wren, input  mwAdress, input  mwData, input  busy);
endinterface

// File: rtl/btn_ram_writer_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and registered rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_p
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise_p  <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            rise_p  <= level & ~level_d;
            // Any sample agreeing with the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/btn_ram_writer.sv
// Manual RAM loader: three debounced buttons drive a one-cycle registered write strobe.
// Optional BTN_RAM_WRITER_AUTO_INC_EN advances the address after every write.
module btn_ram_writer
    import btn_ram_writer_pkg::*;
#(
    parameter int unsigned       ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    parameter int unsigned       DEPTH           = 256,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              bytePos,
    input  logic [2:0]              btn,
    btn_ram_writer_if.master        ram
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(DEPTH - 1);

    logic [2:0]        level;
    logic              wr_p, nx_p, rw_p;
    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [7:0]        data, data_next;
    logic              wren_q, busy_q;

    function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? BASE_ADDR : a + ADDR_W'(1);
    endfunction

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_wr (
        .clk(clk), .rst(rst), .raw(btn[BTN_WR]), .level(level[BTN_WR]), .rise_p(wr_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nx (
        .clk(clk), .rst(rst), .raw(btn[BTN_NX]), .level(level[BTN_NX]), .rise_p(nx_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rw (
        .clk(clk), .rst(rst), .raw(btn[BTN_RW]), .level(level[BTN_RW]), .rise_p(rw_p)
    );

    always_comb begin
        state_next = state;
        addr_next  = addr;
        data_next  = data;
        case (state)
            IDLE: begin
                if (rw_p) begin
                    addr_next = BASE_ADDR;
                end else if (wr_p) begin
                    data_next  = bytePos;
                    state_next = WRITE;
                end else if (nx_p) begin
                    addr_next = adv(addr);
                end
            end
            WRITE: begin
                state_next = IDLE;
`ifdef BTN_RAM_WRITER_AUTO_INC_EN
                addr_next = adv(addr);
`else
                addr_next = addr;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes come from their own flops so the RAM port mux never sees a decode glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr   <= BASE_ADDR;
            data   <= '0;
            wren_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            data   <= data_next;
            wren_q <= (state_next == WRITE);
            busy_q <= (state_next == WRITE);
        end
    end

    assign ram.wren     = wren_q;
    assign ram.busy     = busy_q;
    assign ram.mwAdress = addr;
    assign ram.mwData   = data;
endmodule
